// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared defaults, FSM encodings and elaboration helpers for the instruction fetch controller.
package instr_fetch_ctrl_pkg;

    localparam int unsigned DEF_XLEN     = 32;
    localparam int unsigned DEF_BUS_LEN  = 2;
    localparam int unsigned DEF_MAX_OUT  = 1;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Fetch-side producer for the instruction-alignment buffer: boot/redirect pulses,
// line-aligned memory requests, and in-order delivery with stale-response dropping.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int unsigned     XLEN     = DEF_XLEN,
    parameter int unsigned     BUS_LEN  = DEF_BUS_LEN,
    parameter int unsigned     MAX_OUT  = DEF_MAX_OUT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    core_jump_vld,
    input  logic [XLEN-1:0]         core_jump_pc,
    input  logic                    buffer_free,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_gnt,
    input  logic                    imem_rvld,
    input  logic [BUS_LEN*32-1:0]   imem_rdata,
    output logic                    jump_vld,
    output logic [XLEN-1:0]         jump_pc,
    output logic                    line_vld,
    output logic [BUS_LEN*32-1:0]   line_data
);

    localparam int unsigned     BUS_OFF    = clog2(BUS_LEN * 2);
    localparam int unsigned     CW         = clog2(MAX_OUT + 2);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << (BUS_OFF + 1)) - XLEN'(1));
    localparam logic [XLEN-1:0] LINE_STEP  = XLEN'(BUS_LEN * 4);

    logic [0:0]      state;
    logic [XLEN-1:0] fetch_addr;
    logic [XLEN-1:0] fetch_addr_next;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   discard_next;
    logic            stale;
    logic            granted;
    logic            resp_ok;
    logic            drop;
    logic            redirect;
    logic            issue;
    logic            deliver;

    always_comb begin
        granted  = imem_req && imem_gnt;
        resp_ok  = imem_rvld && (outstanding != '0);
        drop     = resp_ok && (discard != '0);
        redirect = (state == ST_RUN) && core_jump_vld;
        deliver  = resp_ok && !drop && !redirect;

        outstanding_next = outstanding;
        if (granted && !resp_ok)
            outstanding_next = outstanding + CW'(1);
        else if (!granted && resp_ok)
            outstanding_next = outstanding - CW'(1);

        // A request left pending across a redirect is already obsolete; its
        // eventual grant becomes one more response to throw away.
        discard_next = discard;
        if (redirect)
            discard_next = outstanding_next;
        else if (granted && stale && !drop)
            discard_next = discard + CW'(1);
        else if (drop && !(granted && stale))
            discard_next = discard - CW'(1);

        // Granting an obsolete request must not advance the redirected stream.
        fetch_addr_next = fetch_addr;
        if (state == ST_BOOT)
            fetch_addr_next = RESET_PC & ALIGN_MASK;
        else if (redirect)
            fetch_addr_next = core_jump_pc & ALIGN_MASK;
        else if (granted && !stale)
            fetch_addr_next = fetch_addr + LINE_STEP;

        issue = (state == ST_RUN) && (!imem_req || imem_gnt) && buffer_free &&
                (outstanding_next < CW'(MAX_OUT)) && !core_jump_vld;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_BOOT;
            fetch_addr  <= '0;
            outstanding <= '0;
            discard     <= '0;
            stale       <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            jump_vld    <= 1'b0;
            jump_pc     <= '0;
            line_vld    <= 1'b0;
            line_data   <= '0;
        end else begin
            state       <= ST_RUN;
            fetch_addr  <= fetch_addr_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;

            jump_vld <= (state == ST_BOOT) || redirect;
            if (state == ST_BOOT)
                jump_pc <= RESET_PC;
            else if (redirect)
                jump_pc <= core_jump_pc;

            if (redirect)
                stale <= imem_req && !imem_gnt;
            else if (granted)
                stale <= 1'b0;

            if (issue) begin
                imem_req  <= 1'b1;
                imem_addr <= fetch_addr_next;
            end else if (granted) begin
                imem_req  <= 1'b0;
            end

            line_vld <= deliver;
            if (deliver)
                line_data <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && imem_rvld)
            assert (outstanding != '0)
            else $error("instr_fetch_ctrl: imem_rvld with no request outstanding");
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with RESET_PC=0x100, BUS_LEN=2, MAX_OUT=1.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_jump_vld;
    logic [31:0] core_jump_pc;
    logic        buffer_free;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvld;
    logic [63:0] imem_rdata;
    logic        jump_vld;
    logic [31:0] jump_pc;
    logic        line_vld;
    logic [63:0] line_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_fetch_ctrl #(
        .XLEN    (32),
        .BUS_LEN (2),
        .MAX_OUT (1),
        .RESET_PC(32'h0000_0100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_jump_vld(core_jump_vld),
        .core_jump_pc (core_jump_pc),
        .buffer_free  (buffer_free),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvld    (imem_rvld),
        .imem_rdata   (imem_rdata),
        .jump_vld     (jump_vld),
        .jump_pc      (jump_pc),
        .line_vld     (line_vld),
        .line_data    (line_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        core_jump_vld = 1'b0;
        core_jump_pc = '0;
        buffer_free = 1'b0;
        imem_gnt = 1'b0;
        imem_rvld = 1'b0;
        imem_rdata = '0;
        step();
        step();
        check("rst_jump_vld", 64'(jump_vld), 64'd0);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_line_vld", 64'(line_vld), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);

        // Boot
        buffer_free = 1'b1;
        rst = 1'b1;
        step();
        check("boot_jump_vld", 64'(jump_vld), 64'd1);
        check("boot_jump_pc", 64'(jump_pc), 64'h100);
        check("boot_no_req_yet", 64'(imem_req), 64'd0);
        step();
        check("boot_pulse_end", 64'(jump_vld), 64'd0);
        check("first_req", 64'(imem_req), 64'd1);
        check("first_addr", 64'(imem_addr), 64'h100);
        imem_gnt = 1'b1;
        step();
        check("req_drop_after_gnt", 64'(imem_req), 64'd0);
        imem_gnt = 1'b0;
        imem_rvld = 1'b1;
        imem_rdata = 64'h11223344_55667788;
        step();
        check("line1_vld", 64'(line_vld), 64'd1);
        check("line1_data", line_data, 64'h11223344_55667788);
        check("second_req", 64'(imem_req), 64'd1);
        check("second_addr", 64'(imem_addr), 64'h108);
        imem_rvld = 1'b0;
        step();
        check("line_vld_pulse", 64'(line_vld), 64'd0);
        check("second_req_held", 64'(imem_req), 64'd1);

        // Redirect to 0x10A while the 0x108 request is still pending
        core_jump_vld = 1'b1;
        core_jump_pc = 32'h0000_010A;
        step();
        check("redir_jump_vld", 64'(jump_vld), 64'd1);
        check("redir_jump_pc", 64'(jump_pc), 64'h10A);
        check("redir_req_held", 64'(imem_req), 64'd1);
        check("redir_addr_held", 64'(imem_addr), 64'h108);
        core_jump_vld = 1'b0;
        step();
        check("redir_pulse_end", 64'(jump_vld), 64'd0);
        imem_gnt = 1'b1;
        step();
        check("stale_gnt_req_low", 64'(imem_req), 64'd0);
        imem_gnt = 1'b0;
        imem_rvld = 1'b1;
        imem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        check("stale_resp_dropped", 64'(line_vld), 64'd0);
        check("redir_new_req", 64'(imem_req), 64'd1);
        check("redir_new_addr", 64'(imem_addr), 64'h108);
        imem_rvld = 1'b0;

        // Hold a pending request with buffer_free low
        buffer_free = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_req", 64'(imem_req), 64'd1);
            check("hold_addr", 64'(imem_addr), 64'h108);
        end
        imem_gnt = 1'b1;
        step();
        check("hold_gnt_req_low", 64'(imem_req), 64'd0);
        imem_gnt = 1'b0;
        imem_rvld = 1'b1;
        imem_rdata = 64'hA1A2A3A4_B1B2B3B4;
        step();
        check("line2_vld", 64'(line_vld), 64'd1);
        check("line2_data", line_data, 64'hA1A2A3A4_B1B2B3B4);
        check("no_req_when_full", 64'(imem_req), 64'd0);
        imem_rvld = 1'b0;
        step();
        step();
        check("still_no_req", 64'(imem_req), 64'd0);
        buffer_free = 1'b1;
        step();
        check("resume_req", 64'(imem_req), 64'd1);
        check("resume_addr", 64'(imem_addr), 64'h110);

        // Redirect to 0x200 with one response outstanding
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        core_jump_vld = 1'b1;
        core_jump_pc = 32'h0000_0200;
        step();
        check("j200_jump_vld", 64'(jump_vld), 64'd1);
        check("j200_jump_pc", 64'(jump_pc), 64'h200);
        check("j200_no_req", 64'(imem_req), 64'd0);
        core_jump_vld = 1'b0;
        step();
        check("j200_wait_credit", 64'(imem_req), 64'd0);
        imem_rvld = 1'b1;
        imem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        step();
        check("j200_stale_dropped", 64'(line_vld), 64'd0);
        check("j200_req", 64'(imem_req), 64'd1);
        check("j200_addr", 64'(imem_addr), 64'h200);
        imem_rvld = 1'b0;
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvld = 1'b1;
        imem_rdata = 64'h0000_0200_CAFE_0200;
        step();
        check("j200_line_vld", 64'(line_vld), 64'd1);
        check("j200_line_data", line_data, 64'h0000_0200_CAFE_0200);
        check("j200_next_addr", 64'(imem_addr), 64'h208);
        imem_rvld = 1'b0;

        // Redirect coinciding with a response
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        core_jump_vld = 1'b1;
        core_jump_pc = 32'h0000_0300;
        imem_rvld = 1'b1;
        imem_rdata = 64'h5555_5555_5555_5555;
        step();
        check("coinc_line_blocked", 64'(line_vld), 64'd0);
        check("coinc_jump_vld", 64'(jump_vld), 64'd1);
        check("coinc_no_req", 64'(imem_req), 64'd0);
        core_jump_vld = 1'b0;
        imem_rvld = 1'b0;
        step();
        check("coinc_req", 64'(imem_req), 64'd1);
        check("coinc_addr", 64'(imem_addr), 64'h300);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvld = 1'b1;
        imem_rdata = 64'h0000_0300_0000_0300;
        step();
        check("coinc_no_discard", 64'(line_vld), 64'd1);
        check("coinc_line_data", line_data, 64'h0000_0300_0000_0300);
        check("coinc_next_addr", 64'(imem_addr), 64'h308);
        imem_rvld = 1'b0;

        // Asynchronous reset mid-fetch
        rst = 1'b0;
        #1;
        check("arst_req", 64'(imem_req), 64'd0);
        check("arst_addr", 64'(imem_addr), 64'd0);
        check("arst_line_vld", 64'(line_vld), 64'd0);
        check("arst_line_data", line_data, 64'd0);
        check("arst_jump_pc", 64'(jump_pc), 64'd0);
        step();
        rst = 1'b1;
        step();
        check("reboot_jump_vld", 64'(jump_vld), 64'd1);
        check("reboot_jump_pc", 64'(jump_pc), 64'h100);
        step();
        check("reboot_req", 64'(imem_req), 64'd1);
        check("reboot_addr", 64'(imem_addr), 64'h100);

        // Address wrap, with the redirect landing on the grant of a live request
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvld = 1'b1;
        imem_rdata = 64'h0101_0101_0101_0101;
        step();
        check("wrap_pre_line", 64'(line_vld), 64'd1);
        check("wrap_pre_addr", 64'(imem_addr), 64'h108);
        imem_rvld = 1'b0;
        core_jump_vld = 1'b1;
        core_jump_pc = 32'hFFFF_FFFC;
        imem_gnt = 1'b1;
        step();
        check("wrap_jump_pc", 64'(jump_pc), 64'hFFFF_FFFC);
        check("wrap_gnt_req_low", 64'(imem_req), 64'd0);
        core_jump_vld = 1'b0;
        imem_gnt = 1'b0;
        imem_rvld = 1'b1;
        imem_rdata = 64'h0108_0108_0108_0108;
        step();
        check("wrap_stale_dropped", 64'(line_vld), 64'd0);
        check("wrap_addr_top", 64'(imem_addr), 64'hFFFF_FFF8);
        imem_rvld = 1'b0;
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvld = 1'b1;
        imem_rdata = 64'hFFFF_FFF8_1234_5678;
        step();
        check("wrap_line_vld", 64'(line_vld), 64'd1);
        check("wrap_line_data", line_data, 64'hFFFF_FFF8_1234_5678);
        check("wrap_req", 64'(imem_req), 64'd1);
        check("wrap_addr_zero", 64'(imem_addr), 64'h0);
        imem_rvld = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Producer end of the line-delivery interface that feeds the instruction-alignment buffer.
- Turns core redirects into a jump pulse and issues line-aligned fetch requests to instruction memory.
- Forwards returned lines as line_vld/line_data, throttled by the buffer's buffer_free.
- Drops stale responses after a redirect.

Parameters:
- XLEN, 32, address/instruction width.
- BUS_LEN, 2, 32-bit words per fetch line; BUS_WID = BUS_LEN*32; BUS_OFF = log2(BUS_LEN*2), the halfword-offset MSB index.
- MAX_OUT, 1, maximum granted-but-unanswered requests. Values >1 require the consumer to assert buffer_free only with MAX_OUT lines of slack.
- RESET_PC, 32'h0, boot fetch address.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- core_jump_vld  in  1  redirect request from schedule/branch.
- core_jump_pc  in  XLEN  redirect target (halfword aligned).
- buffer_free  in  1  consumer can accept another line.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  line-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle when imem_req=1.
- imem_rvld  in  1  response valid; responses return in request order.
- imem_rdata  in  BUS_WID  response line.
- jump_vld  out  1  redirect pulse to consumer.
- jump_pc  out  XLEN  redirect target to consumer.
- line_vld  out  1  line valid to consumer.
- line_data  out  BUS_WID  line to consumer.

Behaviour:
- All outputs are registered. While rst=0: all outputs 0, state=BOOT, fetch_addr=0, outstanding=0, discard=0.
- BOOT, first clock after rst release:
  - jump_vld=1, jump_pc=RESET_PC on the next cycle.
  - fetch_addr <= align(RESET_PC).
  - State -> RUN.
- align(a): a with bits [BUS_OFF:0] cleared.
- Redirect: core_jump_vld at cycle T gives jump_vld=1 and jump_pc=core_jump_pc at T+1. At the same edge:
  - fetch_addr <= align(core_jump_pc).
  - discard <= outstanding_next, where outstanding_next is the value after T's gnt/rvld accounting.
  - line_vld=0 at T+1, even if imem_rvld at T.
- jump_vld is a single-cycle pulse. Back-to-back redirects give consecutive pulses, and the last redirect wins.
- Request issue: imem_req rises at the edge ending a cycle where all of the following hold:
  - state==RUN;
  - imem_req==0, or imem_req&&imem_gnt;
  - buffer_free==1;
  - outstanding_next<MAX_OUT;
  - core_jump_vld==0.
  imem_addr is driven from fetch_addr.
- Hold rule: once imem_req=1, imem_req and imem_addr stay stable until imem_gnt. A redirect or buffer_free falling does not withdraw a pending request. A pending request granted after a redirect counts into discard: if imem_gnt coincides with the redirect cycle, it is included via outstanding_next; if granted later, discard is incremented.
- On req&&gnt: fetch_addr += BUS_LEN*4, wrapping modulo 2^XLEN; outstanding+1.
- On rvld: outstanding-1. Simultaneous gnt and rvld leaves outstanding unchanged.
- Response: imem_rvld at T with discard==0 and no redirect at T gives line_vld=1 and line_data=imem_rdata at T+1. If discard>0, the response is dropped and discard-1.
- imem_rvld with outstanding==0 is a protocol error: the response is ignored and a simulation assertion fires.
- outstanding and discard are clog2(MAX_OUT+2) bits wide and never wrap.
- Reset mid-operation clears everything asynchronously and re-runs BOOT. In-flight memory responses after reset are the memory's responsibility.

Decomposition:
- Shared define header (existing `define.v`): XLEN, BUS_LEN, BUS_WID, BUS_OFF, HLEN, and the `N/FF macros. New in the header: MAX_OUT and RESET_PC defaults.
- No sub-module. Add a small in-flight counter block inline; it may be factored as instr_fetch_credit if reused by a data-side fetcher.

Test Plan:
- Boot, RESET_PC=0x100, BUS_LEN=2 -> cycle 1 after release: jump_vld=1, jump_pc=0x100. Next: imem_req=1, addr=0x100. gnt, then rvld data 0x11223344_55667788 -> line_vld with that data 1 cycle later; next req addr=0x108.
- Redirect core_jump_pc=0x10A -> jump_pc=0x10A pulse one cycle; next imem_addr=0x108.
- buffer_free=0 -> no new imem_req. A pending req held with gnt=0 for 5 cycles keeps addr constant. buffer_free=1 resumes the sequence.
- Redirect to 0x200 with one response outstanding -> that response produces no line_vld, discard returns to 0, first line_vld carries data for addr 0x200.
- Redirect and imem_rvld in the same cycle, outstanding=1 -> line_vld stays 0, outstanding=0, discard=0.
- rst low mid-fetch (req pending, outstanding=1) -> all outputs 0 immediately. After release, BOOT pulse jump_pc=RESET_PC and addr restarts at align(RESET_PC). Address wrap: fetch at 0xFFFFFFF8 -> next 0x00000000.
